// File: rtl/gf2_clmul_mac.sv
// Pipelined GF(2) carry-less multiply-accumulate: per beat XOR over channels of
// clmul(a_i,b_i), XOR-accumulated over a frame, emitted raw or reduced mod POLY.
module gf2_clmul_mac #(
    parameter int             W    = 8,
    parameter int             NCH  = 2,
    parameter logic [W-1:0]   POLY = 8'h1B,
    parameter int             CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*W-1:0]     in_a,
    input  logic [NCH*W-1:0]     in_b,
    input  logic                 in_last,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*W-2:0]       out_y,
    output logic [CNTW-1:0]      out_cnt
);

    localparam int PW = 2 * W - 1;

    function automatic logic [PW-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                r[i+j] = r[i+j] ^ (x[i] & y[j]);
        return r;
    endfunction

    // Fold the high coefficients top-down; x^W is implicit, so XORing {1,POLY}
    // shifted into place clears bit k while adding its reduction.
    function automatic logic [PW-1:0] reduce(input logic [PW-1:0] v, input logic mode);
        logic [PW-1:0] r;
        logic [PW-1:0] pf;
        logic [PW-1:0] res;
        r       = v;
        pf      = '0;
        pf[W:0] = {1'b1, POLY};
        for (int k = PW - 1; k >= W; k--)
            if (r[k]) r = r ^ (pf << (k - W));
        res        = '0;
        res[W-1:0] = r[W-1:0];
        return mode ? res : v;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [PW-1:0]   prod_p0;
    logic            vld_p1;
    logic [PW-1:0]   prod_p1;
    logic            last_p1;
    logic            mode_p1;
    logic [PW-1:0]   acc_p2;
    logic [CNTW-1:0] cnt_p2;
    logic            s1_advance;
    logic            accept;
    logic [PW-1:0]   acc_next;
    logic [CNTW-1:0] cnt_next;

    always_comb begin
        prod_p0 = '0;
        for (int i = 0; i < NCH; i++)
            prod_p0 = prod_p0 ^ clmul(in_a[i*W +: W], in_b[i*W +: W]);
    end

    // A last beat needs the output register free (or being drained) to move on.
    assign s1_advance = vld_p1 && (!last_p1 || !out_valid || out_ready);
    assign in_ready   = !vld_p1 || s1_advance;
    assign accept     = in_valid && in_ready;
    assign acc_next   = acc_p2 ^ prod_p1;
    assign cnt_next   = sat_inc(cnt_p2);

    // Stage 1: registered beat product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            prod_p1 <= '0;
            last_p1 <= 1'b0;
            mode_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            prod_p1 <= prod_p0;
            last_p1 <= in_last;
            mode_p1 <= in_mode;
        end else if (s1_advance) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage 2: frame accumulation and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p2    <= '0;
            cnt_p2    <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_cnt   <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (s1_advance) begin
                if (last_p1) begin
                    acc_p2    <= '0;
                    cnt_p2    <= '0;
                    out_valid <= 1'b1;
                    out_y     <= reduce(acc_next, mode_p1);
                    out_cnt   <= cnt_next;
                end else begin
                    acc_p2    <= acc_next;
                    cnt_p2    <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_gf2_clmul_mac.sv
// Directed bench for gf2_clmul_mac: single-beat frame table plus hand-written
// multi-beat, backpressure, reset and counter-saturation sequences.
module tb_gf2_clmul_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, in_mode;
    logic [15:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [14:0] out_y;
    logic [7:0]  out_cnt;

    logic        s_in_valid, s_in_ready, s_in_last, s_in_mode;
    logic [7:0]  s_in_a, s_in_b;
    logic        s_out_valid, s_out_ready;
    logic [14:0] s_out_y;
    logic [1:0]  s_out_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    gf2_clmul_mac #(.W(8), .NCH(2), .POLY(8'h1B), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cnt(out_cnt)
    );

    gf2_clmul_mac #(.W(8), .NCH(1), .POLY(8'h1B), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_last(s_in_last), .in_mode(s_in_mode),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_y(s_out_y), .out_cnt(s_out_cnt)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        logic [14:0] y;
        logic [7:0]  cnt;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Entered at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last, input logic mode);
        int n;
        n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last; in_mode = mode;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_mode = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [14:0] y, input logic [7:0] cnt);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_y"}, {17'd0, out_y}, {17'd0, y});
        check({name, "_cnt"}, {24'd0, out_cnt}, {24'd0, cnt});
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0003, 1'b0, 15'h0005, 8'd1, "v_33"};
        vecs[1] = '{16'h0303, 16'h0303, 1'b0, 15'h0000, 8'd1, "v_cancel"};
        vecs[2] = '{16'h0087, 16'h0002, 1'b1, 15'h0015, 8'd1, "v_red87"};
        vecs[3] = '{16'h0087, 16'h0002, 1'b0, 15'h010E, 8'd1, "v_raw87"};
        vecs[4] = '{16'h00FF, 16'h00FF, 1'b0, 15'h5555, 8'd1, "v_rawff"};
        vecs[5] = '{16'h00FF, 16'h00FF, 1'b1, 15'h0013, 8'd1, "v_redff"};
        vecs[6] = '{16'h0201, 16'h8040, 1'b1, 15'h005B, 8'd1, "v_ch1red"};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; in_mode = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_last = 1'b0; s_in_mode = 1'b0;
        s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_y", {17'd0, out_y}, 32'd0);
        check("rst_out_cnt", {24'd0, out_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Two-beat frame; mode on the first beat must be ignored.
        send(16'h0003, 16'h0003, 1'b0, 1'b1);
        send(16'h0001, 16'h00FF, 1'b1, 1'b0);
        check("lat_not_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_two_cycles", {31'd0, out_valid}, 32'd1);
        expect_result("t1", 15'h00FA, 8'd2);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, 1'b1, vecs[i].mode);
            expect_result(vecs[i].name, vecs[i].y, vecs[i].cnt);
        end

        // Backpressure: first result held while a 3-beat frame queues up behind it.
        out_ready = 1'b0;
        send(16'h0003, 16'h0003, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        send(16'h0003, 16'h0003, 1'b0, 1'b0);
        send(16'h0001, 16'h00FF, 1'b0, 1'b0);
        send(16'h0002, 16'h0001, 1'b1, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_hold_y", {17'd0, out_y}, 32'h0005);
        repeat (2) @(negedge clk);
        check("bp_hold_y2", {17'd0, out_y}, 32'h0005);
        check("bp_hold_cnt", {24'd0, out_cnt}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_y", {17'd0, out_y}, 32'h00F8);
        check("bp_second_cnt", {24'd0, out_cnt}, 32'd3);
        @(negedge clk);
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // Reset mid-frame discards the partial frame.
        send(16'h00FF, 16'h00FF, 1'b0, 1'b0);
        send(16'h0011, 16'h0022, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_cnt", {24'd0, out_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(16'h0003, 16'h0003, 1'b1, 1'b0);
        expect_result("after_rst", 15'h0005, 8'd1);

        // Counter saturation on the CNTW=2 instance.
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            s_in_valid = 1'b1; s_in_a = 8'h01; s_in_b = 8'h01; s_in_last = (i == 4);
            while (!s_in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("sat_send_timeout", {31'd0, s_in_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        s_in_valid = 1'b0; s_in_last = 1'b0;
        for (int n = 0; n < 20 && !s_out_valid; n++) @(negedge clk);
        check("sat_valid", {31'd0, s_out_valid}, 32'd1);
        check("sat_cnt", {30'd0, s_out_cnt}, 32'd3);
        check("sat_y", {17'd0, s_out_y}, 32'h0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
